// File: rtl/ps2_note_decoder_pkg.sv
// Shared scancode constants, FSM state and key-class encodings for the PS/2 note decoder.
package ps2_note_decoder_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned NOTE_W = 4;
  localparam int unsigned OCT_W  = 3;
  localparam int unsigned SEL_W  = 3;

  localparam logic [BYTE_W-1:0] SC_BREAK   = 8'hF0;
  localparam logic [BYTE_W-1:0] SC_EXT     = 8'hE0;
  localparam logic [BYTE_W-1:0] SC_OCT_DN  = 8'h1A;
  localparam logic [BYTE_W-1:0] SC_OCT_UP  = 8'h22;
  localparam logic [BYTE_W-1:0] SC_ADSR_DN = 8'h21;
  localparam logic [BYTE_W-1:0] SC_ADSR_UP = 8'h2A;
  localparam logic [BYTE_W-1:0] SC_SEL_1   = 8'h16;
  localparam logic [BYTE_W-1:0] SC_SEL_2   = 8'h1E;
  localparam logic [BYTE_W-1:0] SC_SEL_3   = 8'h26;
  localparam logic [BYTE_W-1:0] SC_SEL_4   = 8'h25;

  localparam logic [BYTE_W-1:0] SC_NOTE_C  = 8'h1C;
  localparam logic [BYTE_W-1:0] SC_NOTE_CS = 8'h1D;
  localparam logic [BYTE_W-1:0] SC_NOTE_D  = 8'h1B;
  localparam logic [BYTE_W-1:0] SC_NOTE_DS = 8'h24;
  localparam logic [BYTE_W-1:0] SC_NOTE_E  = 8'h23;
  localparam logic [BYTE_W-1:0] SC_NOTE_F  = 8'h2B;
  localparam logic [BYTE_W-1:0] SC_NOTE_FS = 8'h2C;
  localparam logic [BYTE_W-1:0] SC_NOTE_G  = 8'h34;
  localparam logic [BYTE_W-1:0] SC_NOTE_GS = 8'h35;
  localparam logic [BYTE_W-1:0] SC_NOTE_A  = 8'h33;
  localparam logic [BYTE_W-1:0] SC_NOTE_AS = 8'h3C;
  localparam logic [BYTE_W-1:0] SC_NOTE_B  = 8'h3B;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BREAK,
    ST_EXT,
    ST_EXT_BRK
  } state_e;

  typedef enum logic [2:0] {
    KC_NONE,
    KC_NOTE,
    KC_OCT_UP,
    KC_OCT_DN,
    KC_ADSR_UP,
    KC_ADSR_DN,
    KC_SEL
  } key_class_e;

  typedef struct packed {
    key_class_e        cls;
    logic [NOTE_W-1:0] idx;
  } key_info_t;

endpackage

// File: rtl/ps2_note_decoder_if.sv
// Byte-strobe input and decoded note/control bus between the PS/2 receiver, decoder and synth.
interface ps2_note_decoder_if;
  import ps2_note_decoder_pkg::*;

  logic [BYTE_W-1:0] ps2_byte;
  logic              ps2_byte_valid;
  logic [NOTE_W-1:0] note;
  logic              note_in;
  logic [OCT_W-1:0]  octave;
  logic              octave_plus_plus;
  logic              octave_minus_minus;
  logic              ADSR_plus_plus;
  logic              ADSR_minus_minus;
  logic [SEL_W-1:0]  ADSR_selector;

  modport master (
    output ps2_byte, ps2_byte_valid,
    input  note, note_in, octave, octave_plus_plus, octave_minus_minus,
           ADSR_plus_plus, ADSR_minus_minus, ADSR_selector
  );

  modport slave (
    input  ps2_byte, ps2_byte_valid,
    output note, note_in, octave, octave_plus_plus, octave_minus_minus,
           ADSR_plus_plus, ADSR_minus_minus, ADSR_selector
  );
endinterface

// File: rtl/ps2_note_decoder_scancode_lookup.sv
// Combinational map from a set-2 scancode to its key class and index.
module ps2_note_decoder_scancode_lookup
  import ps2_note_decoder_pkg::*;
(
  input  logic [BYTE_W-1:0] code_i,
  output key_info_t         key_c_o
);

  always_comb begin
    key_c_o.cls = KC_NONE;
    key_c_o.idx = '0;
    case (code_i)
      SC_NOTE_C:  begin key_c_o.cls = KC_NOTE; key_c_o.idx = 4'd0;  end
      SC_NOTE_CS: begin key_c_o.cls = KC_NOTE; key_c_o.idx = 4'd1;  end
      SC_NOTE_D:  begin key_c_o.cls = KC_NOTE; key_c_o.idx = 4'd2;  end
      SC_NOTE_DS: begin key_c_o.cls = KC_NOTE; key_c_o.idx = 4'd3;  end
      SC_NOTE_E:  begin key_c_o.cls = KC_NOTE; key_c_o.idx = 4'd4;  end
      SC_NOTE_F:  begin key_c_o.cls = KC_NOTE; key_c_o.idx = 4'd5;  end
      SC_NOTE_FS: begin key_c_o.cls = KC_NOTE; key_c_o.idx = 4'd6;  end
      SC_NOTE_G:  begin key_c_o.cls = KC_NOTE; key_c_o.idx = 4'd7;  end
      SC_NOTE_GS: begin key_c_o.cls = KC_NOTE; key_c_o.idx = 4'd8;  end
      SC_NOTE_A:  begin key_c_o.cls = KC_NOTE; key_c_o.idx = 4'd9;  end
      SC_NOTE_AS: begin key_c_o.cls = KC_NOTE; key_c_o.idx = 4'd10; end
      SC_NOTE_B:  begin key_c_o.cls = KC_NOTE; key_c_o.idx = 4'd11; end
      SC_OCT_UP:  key_c_o.cls = KC_OCT_UP;
      SC_OCT_DN:  key_c_o.cls = KC_OCT_DN;
      SC_ADSR_UP: key_c_o.cls = KC_ADSR_UP;
      SC_ADSR_DN: key_c_o.cls = KC_ADSR_DN;
      SC_SEL_1:   begin key_c_o.cls = KC_SEL; key_c_o.idx = 4'd0; end
      SC_SEL_2:   begin key_c_o.cls = KC_SEL; key_c_o.idx = 4'd1; end
      SC_SEL_3:   begin key_c_o.cls = KC_SEL; key_c_o.idx = 4'd2; end
      SC_SEL_4:   begin key_c_o.cls = KC_SEL; key_c_o.idx = 4'd3; end
      default:    ;
    endcase
  end

endmodule

// File: rtl/ps2_note_decoder.sv
// PS/2 set-2 prefix tracker producing the held-note bus, typematic-free adjust pulses,
// saturating octave and envelope-stage selector.
module ps2_note_decoder
  import ps2_note_decoder_pkg::*;
#(
  parameter int unsigned OCT_DEFAULT = 4,
  parameter int unsigned OCT_MIN     = 0,
  parameter int unsigned OCT_MAX     = 7
) (
  input  logic          iClock,
  input  logic          iResetn,
  ps2_note_decoder_if.slave ps2_if
);

  state_e            state_q;
  logic [NOTE_W-1:0] note_q;
  logic              note_in_q;
  logic [OCT_W-1:0]  octave_q;
  logic [SEL_W-1:0]  sel_q;
  logic              oct_up_q, oct_dn_q, adsr_up_q, adsr_dn_q;
  logic              held_oct_up_q, held_oct_dn_q, held_adsr_up_q, held_adsr_dn_q;
  key_info_t         key;

  ps2_note_decoder_scancode_lookup u_lookup (
    .code_i  (ps2_if.ps2_byte),
    .key_c_o (key)
  );

  // Prefix FSM and all output state advance only on accepted byte strobes; pulses self-clear.
  always_ff @(posedge iClock) begin
    if (!iResetn) begin
      state_q        <= ST_IDLE;
      note_q         <= '0;
      note_in_q      <= 1'b0;
      octave_q       <= OCT_W'(OCT_DEFAULT);
      sel_q          <= '0;
      oct_up_q       <= 1'b0;
      oct_dn_q       <= 1'b0;
      adsr_up_q      <= 1'b0;
      adsr_dn_q      <= 1'b0;
      held_oct_up_q  <= 1'b0;
      held_oct_dn_q  <= 1'b0;
      held_adsr_up_q <= 1'b0;
      held_adsr_dn_q <= 1'b0;
    end else begin
      oct_up_q  <= 1'b0;
      oct_dn_q  <= 1'b0;
      adsr_up_q <= 1'b0;
      adsr_dn_q <= 1'b0;
      if (ps2_if.ps2_byte_valid) begin
        case (state_q)
          ST_IDLE: begin
            if (ps2_if.ps2_byte == SC_BREAK) begin
              state_q <= ST_BREAK;
            end else if (ps2_if.ps2_byte == SC_EXT) begin
              state_q <= ST_EXT;
            end else begin
              case (key.cls)
                KC_NOTE: begin
                  note_q    <= key.idx;
                  note_in_q <= 1'b1;
                end
                KC_OCT_UP: if (!held_oct_up_q) begin
                  held_oct_up_q <= 1'b1;
                  oct_up_q      <= 1'b1;
                  if (octave_q < OCT_W'(OCT_MAX)) octave_q <= octave_q + OCT_W'(1);
                end
                KC_OCT_DN: if (!held_oct_dn_q) begin
                  held_oct_dn_q <= 1'b1;
                  oct_dn_q      <= 1'b1;
                  if (octave_q > OCT_W'(OCT_MIN)) octave_q <= octave_q - OCT_W'(1);
                end
                KC_ADSR_UP: if (!held_adsr_up_q) begin
                  held_adsr_up_q <= 1'b1;
                  adsr_up_q      <= 1'b1;
                end
                KC_ADSR_DN: if (!held_adsr_dn_q) begin
                  held_adsr_dn_q <= 1'b1;
                  adsr_dn_q      <= 1'b1;
                end
                KC_SEL:  sel_q <= SEL_W'(key.idx);
                default: ;
              endcase
            end
          end
          ST_BREAK: begin
            state_q <= ST_IDLE;
            case (key.cls)
              KC_NOTE:    if (key.idx == note_q) note_in_q <= 1'b0;
              KC_OCT_UP:  held_oct_up_q  <= 1'b0;
              KC_OCT_DN:  held_oct_dn_q  <= 1'b0;
              KC_ADSR_UP: held_adsr_up_q <= 1'b0;
              KC_ADSR_DN: held_adsr_dn_q <= 1'b0;
              default:    ;
            endcase
          end
          ST_EXT:     state_q <= (ps2_if.ps2_byte == SC_BREAK) ? ST_EXT_BRK : ST_IDLE;
          ST_EXT_BRK: state_q <= ST_IDLE;
          default:    state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign ps2_if.note               = note_q;
  assign ps2_if.note_in            = note_in_q;
  assign ps2_if.octave             = octave_q;
  assign ps2_if.octave_plus_plus   = oct_up_q;
  assign ps2_if.octave_minus_minus = oct_dn_q;
  assign ps2_if.ADSR_plus_plus     = adsr_up_q;
  assign ps2_if.ADSR_minus_minus   = adsr_dn_q;
  assign ps2_if.ADSR_selector      = sel_q;

endmodule
